// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential radix-2 shift-add multiplier with a generic
// operand width, per-operation signed/unsigned mode and optional early
// termination. The core pulses init, waits for the one-cycle done pulse,
// and reads pp, which holds its value until the next operation completes.
//
// Timing: the capture edge loads the operands. Each following edge performs
// one iteration. The edge after the last iteration moves to DONE and
// registers the signed-corrected product. The DONE cycle is also the restart
// window: init held high at the edge leaving DONE begins a new operation
// directly. This gives one result every WIDTH+2 cycles when init is held.
// During CALC, init, A, B and sign_mode are not looked at.
module mult_seq_param #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic               clk,
    input  logic               rst,        // asynchronous, active low
    input  logic               init,
    input  logic               sign_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] pp,
    output logic               busy,
    output logic               done
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;    // shifted multiplicand magnitude
    logic [2*WIDTH-1:0]   acc_q,   acc_d;      // unsigned partial-product sum
    logic [2*WIDTH-1:0]   pp_q,    pp_d;       // registered result
    logic [WIDTH-1:0]     mplier_q, mplier_d;  // remaining multiplier magnitude
    logic [CW-1:0]        cnt_q,   cnt_d;      // iterations still allowed
    logic                 neg_q,   neg_d;      // result must be negated

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 start;
    logic                 calc_finish;

    // The most negative operand negates to itself, which read as unsigned is
    // exactly its magnitude 2^(WIDTH-1), so WIDTH bits always suffice.
    assign a_neg = sign_mode & A[WIDTH-1];
    assign b_neg = sign_mode & B[WIDTH-1];
    assign a_mag = a_neg ? (~A + 1'b1) : A;
    assign b_mag = b_neg ? (~B + 1'b1) : B;

    // A new operation may be captured in IDLE or in the DONE restart window.
    assign start = init & ((state_q == S_IDLE) | (state_q == S_DONE));

    // The finish edge follows the last iteration. Early termination waits
    // until the multiplier has run dry. It also waits for at least one
    // iteration, which is why the counter must have moved off CNT_INIT.
    assign calc_finish = (state_q == S_CALC) &&
                         ((cnt_q == '0) ||
                          (EARLY_TERM && (mplier_q == '0) && (cnt_q != CNT_INIT)));

    // State register with asynchronous abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (init) state_d = S_CALC;
            S_CALC:  if (calc_finish) state_d = S_DONE;
            S_DONE:  state_d = init ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_CALC:  busy = 1'b1;
            S_DONE:  begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next-state: operand capture, shift-add iteration, result load.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        pp_d     = pp_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = CNT_INIT;
            neg_d    = a_neg ^ b_neg;
        end else if ((state_q == S_CALC) && !calc_finish) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_ONE;
        end
        if (calc_finish) begin
            pp_d = neg_q ? (~acc_q + 1'b1) : acc_q;
        end
    end

    // Datapath registers with asynchronous abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            pp_q     <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            pp_q     <= pp_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign pp = pp_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: one instance with EARLY_TERM=0 and one with
// EARLY_TERM=1. The expected product comes from plain integer arithmetic.
// The expected done edge is computed from the iteration-count rule.
module tb_mult_seq_param;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          init_v [2];
    logic          sm_v   [2];
    logic [W-1:0]  a_v    [2];
    logic [W-1:0]  b_v    [2];
    logic [2*W-1:0] pp_w  [2];
    logic          busy_w [2];
    logic          done_w [2];

    int total = 0;
    int bad   = 0;

    mult_seq_param #(.WIDTH(W), .EARLY_TERM(1'b0)) u_dut0 (
        .clk(clk), .rst(rst_n), .init(init_v[0]), .sign_mode(sm_v[0]),
        .A(a_v[0]), .B(b_v[0]), .pp(pp_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    mult_seq_param #(.WIDTH(W), .EARLY_TERM(1'b1)) u_dut1 (
        .clk(clk), .rst(rst_n), .init(init_v[1]), .sign_mode(sm_v[1]),
        .A(a_v[1]), .B(b_v[1]), .pp(pp_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Exact product in 2*W bits, from ordinary integer arithmetic.
    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a,
                                                    input logic [W-1:0] b,
                                                    input logic sm);
        longint p;
        if (sm) p = longint'($signed(a)) * longint'($signed(b));
        else    p = longint'({1'b0, a}) * longint'({1'b0, b});
        return p[2*W-1:0];
    endfunction

    // Edge index (after capture) at which done is expected.
    function automatic int ref_latency(input logic [W-1:0] b, input logic sm, input bit et);
        logic [W-1:0] mag;
        int k;
        if (!et) return W + 1;
        mag = (sm && b[W-1]) ? (~b + 1'b1) : b;
        k = 1;
        for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
        return k + 1;
    endfunction

    // One operation on instance d. With junk set, init/operands are scrambled
    // during CALC, which must not change the result or produce an extra done.
    task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sm, input bit junk);
        logic [2*W-1:0] exp_pp;
        int lat, done_edge, ndone;
        exp_pp = ref_product(a, b, sm);
        lat    = ref_latency(b, sm, d == 1);
        @(negedge clk);
        a_v[d] = a; b_v[d] = b; sm_v[d] = sm; init_v[d] = 1'b1;
        @(posedge clk); #1;
        check("busy_rise", 64'(busy_w[d]), 64'd1);
        done_edge = -1;
        ndone = 0;
        for (int c = 1; c <= lat + 3; c++) begin
            @(negedge clk);
            if (junk && c <= lat) begin
                init_v[d] = 1'($urandom);
                a_v[d]    = W'($urandom);
                b_v[d]    = W'($urandom);
                sm_v[d]   = 1'($urandom);
            end else begin
                init_v[d] = 1'b0;
            end
            @(posedge clk); #1;
            if (done_w[d]) begin
                ndone++;
                if (done_edge < 0) begin
                    done_edge = c;
                    check("pp_at_done", 64'(pp_w[d]), 64'(exp_pp));
                end
            end
            if (c == lat + 1) begin
                check("done_fall", 64'(done_w[d]), 64'd0);
                check("busy_fall", 64'(busy_w[d]), 64'd0);
                check("pp_hold", 64'(pp_w[d]), 64'(exp_pp));
            end
        end
        check("done_edge", 64'(done_edge), 64'(lat));
        check("done_count", 64'(ndone), 64'd1);
        $display("op dut=%0d sm=%0d a=%h b=%h pp=%h exp=%h done_edge=%0d exp_edge=%0d",
                 d, sm, a, b, pp_w[d], exp_pp, done_edge, lat);
    endtask

    initial begin
        int edges [$];
        int ndone;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            init_v[d] = 1'b0; sm_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_pp", 64'(pp_w[d]), 64'd0);
            check("rst_busy", 64'(busy_w[d]), 64'd0);
            check("rst_done", 64'(done_w[d]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, no early termination.
        run_op(0, 16'h00F7, 16'h007F, 1'b0, 1'b0);
        run_op(0, 16'hFFFF, 16'h0003, 1'b1, 1'b0);
        run_op(0, 16'h8000, 16'h8000, 1'b1, 1'b0);
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        run_op(0, 16'h1234, 16'h0000, 1'b0, 1'b0);
        run_op(0, 16'h1234, 16'h0000, 1'b1, 1'b0);
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0);
        check("pp_literal", 64'(pp_w[0]), 64'hFFFF8000);
        run_op(0, 16'h00F7, 16'h007F, 1'b0, 1'b1);

        // Directed cases, early termination.
        run_op(1, 16'h0005, 16'h0003, 1'b0, 1'b0);
        check("et_literal", 64'(pp_w[1]), 64'h0000000F);
        run_op(1, 16'h0005, 16'h0000, 1'b0, 1'b0);
        run_op(1, 16'h8000, 16'h8000, 1'b1, 1'b0);
        run_op(1, 16'h7FFF, 16'hFFFE, 1'b1, 1'b1);

        // Randomized operations on both instances.
        for (int i = 0; i < 40; i++) begin
            run_op(i % 2, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        // init held high: results every W+2 cycles.
        @(negedge clk);
        a_v[0] = 16'd7; b_v[0] = 16'd9; sm_v[0] = 1'b0; init_v[0] = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 3 * (W + 2) + 4; c++) begin
            @(posedge clk); #1;
            if (done_w[0]) begin
                edges.push_back(c);
                check("b2b_pp", 64'(pp_w[0]), 64'd63);
            end
        end
        @(negedge clk);
        init_v[0] = 1'b0;
        check("b2b_count", 64'(edges.size()), 64'd3);
        if (edges.size() >= 3) begin
            check("b2b_first", 64'(edges[0]), 64'(W + 1));
            check("b2b_gap1", 64'(edges[1] - edges[0]), 64'(W + 2));
            check("b2b_gap2", 64'(edges[2] - edges[1]), 64'(W + 2));
        end
        $display("b2b done edges=%p", edges);
        repeat (W + 4) @(negedge clk);

        // Asynchronous reset at iteration 8 aborts the operation.
        @(negedge clk);
        a_v[0] = 16'h1234; b_v[0] = 16'h5678; sm_v[0] = 1'b0; init_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_v[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_pp", 64'(pp_w[0]), 64'd0);
        check("abort_busy", 64'(busy_w[0]), 64'd0);
        check("abort_done", 64'(done_w[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < W + 6; c++) begin
            @(posedge clk); #1;
            if (done_w[0]) ndone++;
        end
        check("abort_nodone", 64'(ndone), 64'd0);
        $display("abort: done pulses after release=%0d", ndone);
        run_op(0, 16'h0002, 16'h0003, 1'b0, 1'b0);
        check("post_abort_pp", 64'(pp_w[0]), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
